// File: rtl/rmt_recovery_walker_if.sv
// Handshake and RMT port bundle for the recovery walker.
// The master side is the recovery manager plus the retirement RMT; the slave side is the walker.
interface rmt_recovery_walker_if #(
  parameter int READ_WIDTH = 2,
  parameter int LREG_BIT   = 6,
  parameter int PREG_BIT   = 7
);
  logic                           recoveryStart;
  logic                           recoveryBusy;
  logic                           recoveryDone;
  logic [READ_WIDTH*LREG_BIT-1:0] rrmtReadLogRegNum;
  logic [READ_WIDTH*PREG_BIT-1:0] rrmtReadPhyRegNum;
  logic [READ_WIDTH-1:0]          rmtWe;
  logic [READ_WIDTH*LREG_BIT-1:0] rmtWriteLogRegNum;
  logic [READ_WIDTH*PREG_BIT-1:0] rmtWritePhyRegNum;

  modport master (
    output recoveryStart, rrmtReadPhyRegNum,
    input  recoveryBusy, recoveryDone, rrmtReadLogRegNum,
    input  rmtWe, rmtWriteLogRegNum, rmtWritePhyRegNum
  );

  modport slave (
    input  recoveryStart, rrmtReadPhyRegNum,
    output recoveryBusy, recoveryDone, rrmtReadLogRegNum,
    output rmtWe, rmtWriteLogRegNum, rmtWritePhyRegNum
  );
endinterface

// File: rtl/rmt_recovery_walker.sv
// Copies the retirement RMT into the rename RMT, READ_WIDTH logical registers per cycle.
// Optional macro RMT_RECOVERY_ZERO_SKIP_EN suppresses the write of logical register 0.
module rmt_recovery_walker #(
  parameter int LREG_NUM   = 64,
  parameter int READ_WIDTH = 2,
  parameter int LREG_BIT   = 6,
  parameter int PREG_BIT   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  rmt_recovery_walker_if.slave  rw
);
  // One extra index bit keeps idx+READ_WIDTH from wrapping past LREG_NUM.
  localparam int IW = LREG_BIT + 1;
  localparam logic [IW-1:0] LN = IW'(LREG_NUM);
  localparam logic [IW-1:0] LW = IW'(READ_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WALK  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [IW-1:0]                  r_idx;
  logic [IW-1:0]                  w_idx_step;
  logic                           w_last;
  logic [READ_WIDTH-1:0]          w_lane_in;
  logic [READ_WIDTH-1:0]          w_lane_we;
  logic [READ_WIDTH*LREG_BIT-1:0] w_rd_addr;
  logic [READ_WIDTH-1:0]          r_we;
  logic [READ_WIDTH*LREG_BIT-1:0] r_wr_addr;
  logic [READ_WIDTH*PREG_BIT-1:0] r_wr_data;
  logic                           r_busy;
  logic                           r_done;
  logic                           w_busy_nxt;
  logic                           w_done_nxt;

  assign w_idx_step = r_idx + LW;
  assign w_last     = (w_idx_step >= LN);

  for (genvar g = 0; g < READ_WIDTH; g++) begin : g_lane
    logic [IW-1:0] w_lane_idx;
    assign w_lane_idx   = r_idx + IW'(g);
    assign w_lane_in[g] = (r_state == S_WALK) && (w_lane_idx < LN);
`ifdef RMT_RECOVERY_ZERO_SKIP_EN
    assign w_lane_we[g] = w_lane_in[g] && (w_lane_idx != {IW{1'b0}});
`else
    assign w_lane_we[g] = w_lane_in[g];
`endif
    assign w_rd_addr[g*LREG_BIT +: LREG_BIT] =
      w_lane_in[g] ? w_lane_idx[LREG_BIT-1:0] : {LREG_BIT{1'b0}};
  end

  // State and walk index; a start in any state rewinds the walk to register 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= {IW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (rw.recoveryStart) begin
        r_idx <= {IW{1'b0}};
      end else if (r_state == S_WALK) begin
        r_idx <= w_idx_step;
      end else begin
        r_idx <= r_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = rw.recoveryStart ? S_WALK : S_IDLE;
      S_WALK: begin
        if (rw.recoveryStart) begin
          w_state_nxt = S_WALK;
        end else if (w_last) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_WALK;
        end
      end
      S_DRAIN: w_state_nxt = rw.recoveryStart ? S_WALK : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Busy/done are computed from the next state so they can be driven from flops.
  always_comb begin
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // One-stage write pipe: this cycle's reads become next cycle's rename-RMT writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we      <= {READ_WIDTH{1'b0}};
      r_wr_addr <= {(READ_WIDTH*LREG_BIT){1'b0}};
      r_wr_data <= {(READ_WIDTH*PREG_BIT){1'b0}};
    end else begin
      r_we      <= w_lane_we;
      r_wr_addr <= w_rd_addr;
      r_wr_data <= rw.rrmtReadPhyRegNum;
    end
  end

  assign rw.recoveryBusy      = r_busy;
  assign rw.recoveryDone      = r_done;
  assign rw.rrmtReadLogRegNum = w_rd_addr;
  assign rw.rmtWe             = r_we;
  assign rw.rmtWriteLogRegNum = r_wr_addr;
  assign rw.rmtWritePhyRegNum = r_wr_data;
endmodule

// File: tb/tb_rmt_recovery_walker.sv
// Drives a 64-register and a 5-register walker against a phase-count reference model.
module tb_rmt_recovery_walker;
  logic clk;
  logic rst;
  logic [6:0] rrmt [64];
  int n_checks;
  int n_errors;
  int cyc;

`ifdef RMT_RECOVERY_ZERO_SKIP_EN
  localparam bit SKIP0 = 1'b1;
`else
  localparam bit SKIP0 = 1'b0;
`endif

  rmt_recovery_walker_if #(.READ_WIDTH(2), .LREG_BIT(6), .PREG_BIT(7)) ifa ();
  rmt_recovery_walker_if #(.READ_WIDTH(2), .LREG_BIT(3), .PREG_BIT(7)) ifb ();

  rmt_recovery_walker #(.LREG_NUM(64), .READ_WIDTH(2), .LREG_BIT(6), .PREG_BIT(7)) dut_a (
    .clk(clk), .rst(rst), .rw(ifa)
  );
  rmt_recovery_walker #(.LREG_NUM(5), .READ_WIDTH(2), .LREG_BIT(3), .PREG_BIT(7)) dut_b (
    .clk(clk), .rst(rst), .rw(ifb)
  );

  // Retirement RMT: combinational read data for both walkers.
  assign ifa.rrmtReadPhyRegNum = {rrmt[ifa.rrmtReadLogRegNum[11:6]], rrmt[ifa.rrmtReadLogRegNum[5:0]]};
  assign ifb.rrmtReadPhyRegNum = {rrmt[{3'b000, ifb.rrmtReadLogRegNum[5:3]}],
                                  rrmt[{3'b000, ifb.rrmtReadLogRegNum[2:0]}]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase = cycles since the last accepted start (0 idle, 1..K walk, K+1 drain).
  int m_phase [2];
  bit m_wv [2][2];
  int m_wa [2][2];
  int m_wd [2][2];

  function automatic int n_of(int d);
    return (d == 0) ? 64 : 5;
  endfunction

  function automatic int k_of(int d);
    return (n_of(d) + 1) / 2;
  endfunction

  function automatic bit lane_in(int d, int l);
    int p;
    p = m_phase[d];
    if (p < 1 || p > k_of(d)) return 1'b0;
    return (2 * (p - 1) + l) < n_of(d);
  endfunction

  function automatic int lane_addr(int d, int l);
    return lane_in(d, l) ? 2 * (m_phase[d] - 1) + l : 0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_dut(input string p, input int d, input logic busy, input logic done,
                           input logic [1:0] we, input int rd0, input int rd1,
                           input int wa0, input int wa1, input int wd0, input int wd1);
    int rd [2];
    int wa [2];
    int wd [2];
    rd[0] = rd0; rd[1] = rd1; wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1;
    check_eq({p, ".busy"}, {31'd0, busy}, {31'd0, m_phase[d] != 0});
    check_eq({p, ".done"}, {31'd0, done}, {31'd0, m_phase[d] == k_of(d) + 1});
    for (int l = 0; l < 2; l++) begin
      check_eq({p, ".rdaddr"}, rd[l], lane_addr(d, l));
      check_eq({p, ".we"}, {31'd0, we[l]}, {31'd0, m_wv[d][l]});
      if (m_wv[d][l]) begin
        check_eq({p, ".waddr"}, wa[l], m_wa[d][l]);
        check_eq({p, ".wdata"}, wd[l], m_wd[d][l]);
      end
    end
  endtask

  task automatic model_edge(input int d, input bit st, input bit r);
    int a;
    if (r) begin
      m_phase[d] = 0;
      for (int l = 0; l < 2; l++) m_wv[d][l] = 1'b0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        a = lane_addr(d, l);
        m_wv[d][l] = lane_in(d, l) && !(SKIP0 && a == 0);
        m_wa[d][l] = a;
        m_wd[d][l] = int'(rrmt[a]);
      end
      if (st) m_phase[d] = 1;
      else if (m_phase[d] == 0 || m_phase[d] == k_of(d) + 1) m_phase[d] = 0;
      else m_phase[d] = m_phase[d] + 1;
    end
  endtask

  task automatic step(input bit sa, input bit sb, input bit r, input bit mutate);
    @(negedge clk);
    cyc++;
    check_dut("A", 0, ifa.recoveryBusy, ifa.recoveryDone, ifa.rmtWe,
              int'(ifa.rrmtReadLogRegNum[5:0]), int'(ifa.rrmtReadLogRegNum[11:6]),
              int'(ifa.rmtWriteLogRegNum[5:0]), int'(ifa.rmtWriteLogRegNum[11:6]),
              int'(ifa.rmtWritePhyRegNum[6:0]), int'(ifa.rmtWritePhyRegNum[13:7]));
    check_dut("B", 1, ifb.recoveryBusy, ifb.recoveryDone, ifb.rmtWe,
              int'(ifb.rrmtReadLogRegNum[2:0]), int'(ifb.rrmtReadLogRegNum[5:3]),
              int'(ifb.rmtWriteLogRegNum[2:0]), int'(ifb.rmtWriteLogRegNum[5:3]),
              int'(ifb.rmtWritePhyRegNum[6:0]), int'(ifb.rmtWritePhyRegNum[13:7]));
    ifa.recoveryStart = sa;
    ifb.recoveryStart = sb;
    rst = r;
    if (mutate) rrmt[$urandom_range(63, 0)] = 7'($urandom);
    model_edge(0, sa, r);
    model_edge(1, sb, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    for (int r = 0; r < 64; r++) rrmt[r] = 7'(r + 64);
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0;
      for (int l = 0; l < 2; l++) begin
        m_wv[d][l] = 1'b0; m_wa[d][l] = 0; m_wd[d][l] = 0;
      end
    end
    rst = 1'b1;
    ifa.recoveryStart = 1'b0;
    ifb.recoveryStart = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst.waddrA", {20'd0, ifa.rmtWriteLogRegNum}, 32'd0);
    check_eq("rst.wdataA", {18'd0, ifa.rmtWritePhyRegNum}, 32'd0);
    check_eq("rst.wdataB", {18'd0, ifb.rmtWritePhyRegNum}, 32'd0);

    // Full walk on both sizes
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(40);
    // Restart mid-walk
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(40);
    // Reset mid-walk, then a clean walk
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(40);
    // Start during the drain cycle
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(32);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(40);
    // Start held high
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(40);
    // Random starts, resets and RRMT updates
    for (int i = 0; i < 500; i++)
      step(($urandom_range(23, 0) == 0), ($urandom_range(7, 0) == 0),
           ($urandom_range(199, 0) == 0), 1'b1);
    idle(40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
